// File: rtl/ble_rx_word_packer.sv
// ble_rx_word_packer: packs a decoded BLE bit stream LSB-first into DATA-bit
// words, buffers the words in an output FIFO and reports frame completion
// through an interrupt flag or a DMA request handshake.
module ble_rx_word_packer #(
    parameter int DATA  = 32,   // packed word width, 8..64
    parameter int DEPTH = 16,   // FIFO depth in words, power of 2, >= 2
    parameter int CNT_W = 16    // frame word counter width
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   bit_in,
    input  logic                   bit_valid,
    input  logic                   frame_end,
    input  logic                   frame_error,
    input  logic                   rd_en,
    output logic [DATA-1:0]        rd_data,
    output logic                   fifo_empty,
    output logic                   fifo_full,
    output logic [$clog2(DEPTH):0] level,
    input  logic                   irq_en,
    input  logic                   irq_clear,
    input  logic                   dma_mode,
    input  logic                   dma_ack,
    input  logic                   dma_done,
    output logic                   irq,
    output logic                   dma_req,
    output logic                   err_out,
    output logic                   overflow,
    output logic [CNT_W-1:0]       word_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int BW = $clog2(DATA);
    localparam logic [BW-1:0] LAST_BIT   = BW'(DATA - 1);
    localparam logic [AW:0]   FULL_LEVEL = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RECV  = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    // Bit packer
    logic [DATA-1:0] acc;         // partial word; bits above bit_cnt are always zero
    logic [BW-1:0]   bit_cnt;     // index of the next bit position to fill
    logic [DATA-1:0] bit_mask;
    logic [DATA-1:0] acc_with_bit;

    // FSM-decoded controls
    logic            accept_bit;
    logic            word_done;
    logic            partial_pending;
    logic            enter_recv;
    logic            enter_done;
    logic            push_req;
    logic [DATA-1:0] push_word;
    logic            err_set;

    // FIFO
    logic [DATA-1:0] mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            pop_ok;
    logic            push_ok;

    // Completion handshakes
    logic            irq_flag;
    logic            dma_flag;
    logic            ack_seen;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------

    // State register
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state is written with non-blocking (<=) so every
        // register samples pre-edge values; combinational blocks use blocking (=).
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (bit_valid) begin
                    state_next = S_RECV;
                end
            end
            S_RECV: begin
                // A bit arriving with frame_end is already folded into
                // partial_pending, so it is packed before the end is handled.
                if (frame_end) begin
                    state_next = partial_pending ? S_FLUSH : S_DONE;
                end
            end
            S_FLUSH: begin
                state_next = S_DONE;
            end
            S_DONE: begin
                if (irq_clear || dma_done) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Output decode: bit acceptance, word push requests and event strobes
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the block can infer a latch.
        accept_bit      = 1'b0;
        word_done       = 1'b0;
        partial_pending = 1'b0;
        enter_recv      = 1'b0;
        enter_done      = 1'b0;
        push_req        = 1'b0;
        push_word       = acc;
        err_set         = 1'b0;

        // Bits are taken only while a frame is being received; FLUSH and
        // DONE silently drop them.
        accept_bit = bit_valid && ((state == S_IDLE) || (state == S_RECV));
        word_done  = accept_bit && (bit_cnt == LAST_BIT);

        // Something is left to flush if the counter will be non-zero after
        // this cycle's bit (if any) is taken.
        if (accept_bit) begin
            partial_pending = !word_done;
        end else begin
            partial_pending = (bit_cnt != '0);
        end

        enter_recv = (state == S_IDLE) && bit_valid;
        enter_done = (state != S_DONE) && (state_next == S_DONE);

        if (state == S_FLUSH) begin
            // acc is already zero above the last filled bit: this is the pad.
            push_req  = 1'b1;
            push_word = acc;
        end else if (word_done) begin
            push_req  = 1'b1;
            push_word = acc_with_bit;
        end

        err_set = frame_error && ((state == S_RECV) || (state == S_FLUSH));
    end

    // ------------------------------------------------------------------
    // Bit packer
    // ------------------------------------------------------------------

    assign bit_mask     = {{(DATA - 1){1'b0}}, 1'b1} << bit_cnt;
    assign acc_with_bit = bit_in ? (acc | bit_mask) : acc;

    // Accumulate bits LSB-first; clear after each full word or flush
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc     <= '0;
            bit_cnt <= '0;
        end else if (state == S_FLUSH) begin
            acc     <= '0;
            bit_cnt <= '0;
        end else if (accept_bit) begin
            if (word_done) begin
                acc     <= '0;
                bit_cnt <= '0;
            end else begin
                acc     <= acc_with_bit;
                bit_cnt <= bit_cnt + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output FIFO
    // ------------------------------------------------------------------

    // Push/pop qualification; a full FIFO still accepts a push when a pop
    // frees the head slot in the same cycle.
    always_comb begin
        pop_ok  = rd_en && (level != '0);
        push_ok = push_req && ((level != FULL_LEVEL) || pop_ok);
    end

    assign fifo_empty = (level == '0);
    assign fifo_full  = (level == FULL_LEVEL);

    // Storage write
    always_ff @(posedge clk) begin
        // NOTE: the storage array is deliberately not reset; occupancy lives
        // in level and the pointers, so stale contents are never read.
        if (push_ok) begin
            mem[wr_ptr] <= push_word;
        end
    end

    // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // Registered read port; holds its value when no pop occurs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data <= '0;
        end else if (pop_ok) begin
            rd_data <= mem[rd_ptr];
        end
    end

    // ------------------------------------------------------------------
    // Frame status
    // ------------------------------------------------------------------

    // Per-frame word counter, saturating; restarts on the first bit of a frame
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word_count <= '0;
        end else if (enter_recv) begin
            word_count <= '0;
        end else if (push_ok && (word_count != '1)) begin
            word_count <= word_count + 1'b1;
        end
    end

    // Sticky frame error; the first-bit cycle already belongs to the new frame
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_out <= 1'b0;
        end else if (enter_recv) begin
            err_out <= frame_error;
        end else if (err_set) begin
            err_out <= 1'b1;
        end
    end

    // Sticky overflow on a dropped push; only irq_clear acknowledges it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (irq_clear) begin
            overflow <= 1'b0;
        end else if (push_req && !push_ok) begin
            overflow <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Completion handshakes
    // ------------------------------------------------------------------

    // Interrupt flag: set on DONE entry, clear wins over a same-cycle set
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_flag <= 1'b0;
        end else if (irq_clear) begin
            irq_flag <= 1'b0;
        end else if (enter_done) begin
            irq_flag <= 1'b1;
        end
    end

    // DMA ack latch; dma_done closes the transfer and re-arms it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ack_seen <= 1'b0;
        end else if (dma_done) begin
            ack_seen <= 1'b0;
        end else if (dma_ack) begin
            ack_seen <= 1'b1;
        end
    end

    // DMA request flag: set on DONE entry, dropped the cycle after the ack is seen
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dma_flag <= 1'b0;
        end else if (enter_done) begin
            dma_flag <= 1'b1;
        end else if (ack_seen) begin
            dma_flag <= 1'b0;
        end
    end

    assign irq     = irq_flag & irq_en;
    assign dma_req = dma_flag & dma_mode;

endmodule

// File: tb/tb_ble_rx_word_packer.sv
// Directed self-checking bench for ble_rx_word_packer (DATA=32, DEPTH=4).
// Expected FIFO words are pushed to a scoreboard queue as the bits are driven
// and popped when the bench reads the FIFO.
module tb_ble_rx_word_packer;

    localparam int DATA  = 32;
    localparam int DEPTH = 4;
    localparam int CNT_W = 16;

    localparam logic [63:0] ST_IDLE  = 64'd0;
    localparam logic [63:0] ST_RECV  = 64'd1;
    localparam logic [63:0] ST_FLUSH = 64'd2;
    localparam logic [63:0] ST_DONE  = 64'd3;

    logic                   clk;
    logic                   reset;
    logic                   bit_in;
    logic                   bit_valid;
    logic                   frame_end;
    logic                   frame_error;
    logic                   rd_en;
    logic [DATA-1:0]        rd_data;
    logic                   fifo_empty;
    logic                   fifo_full;
    logic [$clog2(DEPTH):0] level;
    logic                   irq_en;
    logic                   irq_clear;
    logic                   dma_mode;
    logic                   dma_ack;
    logic                   dma_done;
    logic                   irq;
    logic                   dma_req;
    logic                   err_out;
    logic                   overflow;
    logic [CNT_W-1:0]       word_count;

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0] exp_q[$];
    int          model_level = 0;

    ble_rx_word_packer #(
        .DATA (DATA),
        .DEPTH(DEPTH),
        .CNT_W(CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bit_in     (bit_in),
        .bit_valid  (bit_valid),
        .frame_end  (frame_end),
        .frame_error(frame_error),
        .rd_en      (rd_en),
        .rd_data    (rd_data),
        .fifo_empty (fifo_empty),
        .fifo_full  (fifo_full),
        .level      (level),
        .irq_en     (irq_en),
        .irq_clear  (irq_clear),
        .dma_mode   (dma_mode),
        .dma_ack    (dma_ack),
        .dma_done   (dma_done),
        .irq        (irq),
        .dma_req    (dma_req),
        .err_out    (err_out),
        .overflow   (overflow),
        .word_count (word_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case anything ever stalls
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Advance one clock; inputs driven and outputs sampled 1 ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_expected(input logic [31:0] w);
        if (model_level < DEPTH) begin
            exp_q.push_back(w);
            model_level++;
        end
    endtask

    task automatic read_word(input string tag);
        logic [31:0] exp_w;
        if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $error("FAIL %s: scoreboard has no expected word (observed level %0d)", tag, level);
        end else begin
            exp_w = exp_q.pop_front();
            model_level--;
            rd_en = 1'b1;
            tick();
            rd_en = 1'b0;
            check(tag, 64'(rd_data), 64'(exp_w));
        end
    endtask

    task automatic pulse_irq_clear();
        irq_clear = 1'b1;
        tick();
        irq_clear = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_rd_data"},    64'(rd_data),    64'd0);
        check({tag, "_level"},      64'(level),      64'd0);
        check({tag, "_empty"},      64'(fifo_empty), 64'd1);
        check({tag, "_full"},       64'(fifo_full),  64'd0);
        check({tag, "_word_count"}, 64'(word_count), 64'd0);
        check({tag, "_err_out"},    64'(err_out),    64'd0);
        check({tag, "_overflow"},   64'(overflow),   64'd0);
        check({tag, "_irq"},        64'(irq),        64'd0);
        check({tag, "_dma_req"},    64'(dma_req),    64'd0);
        check({tag, "_state"},      64'(dut.state),  ST_IDLE);
    endtask

    // Drive nbits of data LSB-first as one frame. frame_end rides on the last
    // bit or follows in its own cycle; frame_error pulses at bit err_at; a pop
    // is issued together with bit pop_at. Expected words enter the scoreboard.
    task automatic send_frame(input logic [255:0] data, input int nbits, input bit end_with_last,
                              input int err_at, input int pop_at);
        logic [31:0] popped;
        logic [31:0] part;
        int          base;
        popped = '0;
        for (int i = 0; i < nbits; i++) begin
            bit_in      = data[i];
            bit_valid   = 1'b1;
            frame_end   = end_with_last && (i == nbits - 1);
            frame_error = (i == err_at);
            rd_en       = (i == pop_at);
            if ((i == pop_at) && (exp_q.size() > 0)) begin
                popped = exp_q.pop_front();
                model_level--;
            end
            if (((i + 1) % 32) == 0) begin
                base = i - 31;
                push_expected(data[base +: 32]);
            end
            tick();
            if (i == 0) begin
                check("first_bit_state",      64'(dut.state),  ST_RECV);
                check("first_bit_word_count", 64'(word_count), 64'd0);
                check("first_bit_err_out",    64'(err_out),    64'(err_at == 0));
            end
            if (i == pop_at) begin
                check("pop_during_frame", 64'(rd_data), 64'(popped));
            end
        end
        bit_in      = 1'b0;
        bit_valid   = 1'b0;
        frame_end   = 1'b0;
        frame_error = 1'b0;
        rd_en       = 1'b0;
        if (!end_with_last) begin
            frame_end = 1'b1;
            tick();
            frame_end = 1'b0;
        end
        if ((nbits % 32) != 0) begin
            base = (nbits / 32) * 32;
            part = data[base +: 32] & ((32'h1 << (nbits % 32)) - 32'h1);
            push_expected(part);
        end
    endtask

    initial begin
        reset       = 1'b1;
        bit_in      = 1'b0;
        bit_valid   = 1'b0;
        frame_end   = 1'b0;
        frame_error = 1'b0;
        rd_en       = 1'b0;
        irq_en      = 1'b1;
        irq_clear   = 1'b0;
        dma_mode    = 1'b1;
        dma_ack     = 1'b0;
        dma_done    = 1'b0;

        // Reset state
        tick();
        tick();
        check_reset_state("reset");
        reset    = 1'b0;
        dma_mode = 1'b0;
        tick();

        // Two full words, frame_end on its own cycle: no FLUSH
        send_frame(256'hA5A5A5A5_0F0F0F0F, 64, 1'b0, -1, -1);
        check("full_state_done", 64'(dut.state),  ST_DONE);
        check("full_word_count", 64'(word_count), 64'd2);
        check("full_level",      64'(level),      64'(model_level));
        check("full_irq",        64'(irq),        64'd1);
        check("full_err_out",    64'(err_out),    64'd0);
        read_word("full_word0");
        read_word("full_word1");
        pulse_irq_clear();
        check("full_clr_state", 64'(dut.state), ST_IDLE);
        check("full_clr_irq",   64'(irq),       64'd0);

        // 40 bits with frame_end on the last bit: partial word goes via FLUSH
        send_frame(256'hFF_12345678, 40, 1'b1, -1, -1);
        check("part_state_flush", 64'(dut.state), ST_FLUSH);
        tick();
        check("part_state_done", 64'(dut.state),  ST_DONE);
        check("part_word_count", 64'(word_count), 64'd2);
        check("part_level",      64'(level),      64'(model_level));
        check("part_irq",        64'(irq),        64'd1);
        irq_en = 1'b0;
        #1;
        check("part_irq_masked", 64'(irq), 64'd0);
        irq_en = 1'b1;
        read_word("part_word0");
        read_word("part_word1_padded");
        pulse_irq_clear();
        check("part_clr_state", 64'(dut.state), ST_IDLE);

        // Five words into a 4-deep FIFO with no reads: fifth is dropped
        send_frame(256'h55555555_44444444_33333333_22222222_11111111, 160, 1'b0, -1, -1);
        check("ovf_level",      64'(level),      64'd4);
        check("ovf_full",       64'(fifo_full),  64'd1);
        check("ovf_empty",      64'(fifo_empty), 64'd0);
        check("ovf_flag",       64'(overflow),   64'd1);
        check("ovf_word_count", 64'(word_count), 64'd4);
        pulse_irq_clear();
        check("ovf_clr_flag",  64'(overflow),  64'd0);
        check("ovf_clr_state", 64'(dut.state), ST_IDLE);
        for (int k = 0; k < 4; k++) begin
            read_word("ovf_word");
        end
        check("ovf_drained_empty", 64'(fifo_empty), 64'd1);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check("empty_read_hold",  64'(rd_data), 64'h44444444);
        check("empty_read_level", 64'(level),   64'd0);

        // Push and pop in the same cycle while full: both succeed
        send_frame(256'hCAFE0005_CAFE0004_CAFE0003_CAFE0002_CAFE0001, 160, 1'b0, -1, 159);
        check("pp_level",      64'(level),      64'(model_level));
        check("pp_overflow",   64'(overflow),   64'd0);
        check("pp_word_count", 64'(word_count), 64'd5);
        for (int k = 0; k < 4; k++) begin
            read_word("pp_word");
        end
        pulse_irq_clear();

        // DMA handshake
        irq_en   = 1'b0;
        dma_mode = 1'b1;
        send_frame(256'h600DF00D, 32, 1'b0, -1, -1);
        check("dma_req_set", 64'(dma_req), 64'd1);
        check("dma_irq_off", 64'(irq),     64'd0);
        dma_ack = 1'b1;
        tick();
        dma_ack = 1'b0;
        check("dma_req_after_ack1", 64'(dma_req), 64'd1);
        tick();
        check("dma_req_after_ack2", 64'(dma_req), 64'd0);
        dma_done = 1'b1;
        tick();
        dma_done = 1'b0;
        check("dma_done_state", 64'(dut.state), ST_IDLE);
        read_word("dma_word");
        dma_mode = 1'b0;
        irq_en   = 1'b1;

        // Frame error is sticky past DONE and clears on the next frame's first bit
        send_frame(256'h13579BDF, 32, 1'b0, 10, -1);
        check("err_done_state", 64'(dut.state), ST_DONE);
        check("err_sticky",     64'(err_out),   64'd1);
        pulse_irq_clear();
        check("err_idle_held",  64'(err_out),   64'd1);
        read_word("err_word");
        send_frame(256'h2468ACE0, 32, 1'b0, -1, -1);
        check("err_clean_frame", 64'(err_out), 64'd0);
        check("err_clean_level", 64'(level),   64'(model_level));
        pulse_irq_clear();

        // Reset mid-frame after 17 bits discards everything
        for (int i = 0; i < 17; i++) begin
            bit_in    = i[0];
            bit_valid = 1'b1;
            tick();
        end
        bit_valid = 1'b0;
        bit_in    = 1'b0;
        dma_mode  = 1'b1;
        reset     = 1'b1;
        #1;
        check("async_reset_level", 64'(level),     64'd0);
        check("async_reset_state", 64'(dut.state), ST_IDLE);
        exp_q.delete();
        model_level = 0;
        tick();
        reset = 1'b0;
        tick();
        check_reset_state("midreset");
        dma_mode = 1'b0;
        tick();
        check("midreset_no_push", 64'(level), 64'd0);
        send_frame(256'h0BADBEEF, 32, 1'b0, -1, -1);
        check("post_reset_level",      64'(level),      64'd1);
        check("post_reset_word_count", 64'(word_count), 64'd1);
        read_word("post_reset_word");
        check("post_reset_empty", 64'(fifo_empty), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ble_rx_word_packer.md
BLE_RX_WORD_PACKER -- requirements
Module: ble_rx_word_packer

Interface
REQ-001 SHALL have parameter DATA, default 32: packed word width, legal range 8..64.
REQ-002 SHALL have parameter DEPTH, default 16: output FIFO depth in words, power of 2, at least 2.
REQ-003 SHALL have parameter CNT_W, default 16: width of the frame word counter.
REQ-004 SHALL use a single clock and an asynchronous, active-high reset (decided): port clk, input, 1, sole clock, all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port bit_in, input, 1: decoded serial bit.
REQ-007 SHALL have port bit_valid, input, 1: bit_in qualifier.
REQ-008 SHALL have port frame_end, input, 1: one-cycle pulse; last bit of frame is at or before this cycle.
REQ-009 SHALL have port frame_error, input, 1: decoder CRC/HEC error; sampled any cycle of a frame.
REQ-010 SHALL have port rd_en, input, 1: pop request from the bus side.
REQ-011 SHALL have port rd_data, output, DATA: registered FIFO read word.
REQ-012 SHALL have ports fifo_empty and fifo_full, output, 1 each: FIFO status.
REQ-013 SHALL have port level, output, log2(DEPTH)+1: current FIFO occupancy.
REQ-014 SHALL have ports irq_en, irq_clear, dma_mode, dma_ack and dma_done, input, 1 each: control handshakes.
REQ-015 SHALL have ports irq and dma_req, output, 1 each: completion interrupt and DMA request.
REQ-016 SHALL have ports err_out and overflow, output, 1 each: sticky frame error and sticky FIFO overflow.
REQ-017 SHALL have port word_count, output, CNT_W: words pushed in the current or last frame.

Function
REQ-018 SHALL implement FSM IDLE, RECV, FLUSH, DONE: IDLE->RECV on first bit_valid; RECV->FLUSH on frame_end with a partial word pending; RECV->DONE on frame_end with none pending; FLUSH->DONE unconditionally after 1 cycle; DONE->IDLE on irq_clear or dma_done.
REQ-019 SHALL pack bits LSB-first; the first bit of each word goes to bit 0.
REQ-020 SHALL push the word in the cycle its DATA-th bit is accepted; the word appears in the FIFO next cycle (level +1).
REQ-021 SHALL accept a bit presented with bit_valid and frame_end in the same cycle as part of the frame, before the end is processed.
REQ-022 SHALL zero-pad the remaining upper bits of a partial word in FLUSH and push it.
REQ-023 SHALL drop bit_valid while in FLUSH or DONE without counting or pushing; frame_end in IDLE SHALL be ignored.
REQ-024 SHALL clear word_count and err_out on IDLE->RECV, and increment word_count per successful push, saturating at all-ones.
REQ-025 SHALL set err_out if frame_error is high in any RECV or FLUSH cycle, or in the frame_end cycle.
REQ-026 SHALL drop a push to a full FIFO, set overflow, and not increment word_count; a simultaneous push and pop when full SHALL both succeed.
REQ-027 SHALL load rd_data with the head word the cycle after rd_en when the FIFO is non-empty; rd_en when empty SHALL be ignored and rd_data held.
REQ-028 SHALL wrap the FIFO pointers modulo DEPTH.
REQ-029 SHALL set irq_flag on entry to DONE and clear it on irq_clear, with clear winning a same-cycle set; irq = irq_flag AND irq_en, combinational.
REQ-030 SHALL set dma_flag on entry to DONE; dma_req = dma_flag AND dma_mode.
REQ-031 SHALL latch dma_ack into ack_seen; dma_flag SHALL clear the cycle after ack_seen is set; ack_seen SHALL clear on dma_done.
REQ-032 SHALL clear overflow only on irq_clear.

Reset
REQ-033 SHALL, on reset, clear the FSM to IDLE and clear FIFO pointers, level, rd_data, word_count, err_out, overflow, irq, dma_req and all flags; fifo_empty=1, fifo_full=0.
REQ-034 SHALL, on reset asserted mid-frame, discard all partial and stored data, with no push on release.

Verification
REQ-035 SHALL verify: DATA=32, 64 bits 0xA5A5A5A5_0F0F0F0F LSB-first then frame_end -> FIFO holds 0x0F0F0F0F then 0xA5A5A5A5, word_count=2, no FLUSH.
REQ-036 SHALL verify: 40 bits, last 8 = 0xFF, frame_end with the last bit -> second word 0x000000FF via FLUSH, word_count=2, irq=1 when irq_en=1.
REQ-037 SHALL verify: DEPTH=4, 5 words with no reads -> level=4, fifo_full=1, overflow=1, word_count=4; irq_clear -> overflow=0, FSM in IDLE.
REQ-038 SHALL verify: dma_mode=1, frame completes -> dma_req=1; dma_ack pulse -> dma_req=0 two cycles later; dma_done -> FSM IDLE.
REQ-039 SHALL verify: frame_error pulse mid-frame -> err_out=1 after DONE; next frame clean -> err_out cleared on first bit.
REQ-040 SHALL verify: reset after 17 bits -> all outputs at reset values; new 32-bit frame -> exactly one correct word.
